// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared state encoding and default sizing for the scrub controller
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TMR,
        READ,
        WAIT_DEC,
        WRITE,
        NEXT
    } state_e;

    localparam int ADDR_W_DEF     = 10;
    localparam int DEPTH_DEF      = 1024;
    localparam int DATA_W_DEF     = 64;
    localparam int INTERVAL_W_DEF = 16;

endpackage

// File: rtl/ecc_scrub_ctrl_scrub_timer.sv
// scrub_timer: loadable down-counter that holds at zero and flags it
module scrub_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: walks the SECDED array, writes back single-bit fixes, logs double-bit errors
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int INTERVAL_W = INTERVAL_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  host_busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  dec_valid,
    input  logic [DATA_W-1:0]     dec_data,
    input  logic                  dec_single,
    input  logic                  dec_double,
    output logic                  scrub_valid,
    output logic                  scrub_single,
    output logic                  scrub_double,
    output logic [ADDR_W-1:0]     err_addr,
    output logic                  err_irq,
    input  logic                  irq_clr,
    output logic                  pass_done,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic                    w_zero;
    logic                    w_load;
    logic [INTERVAL_W-1:0]   w_load_val;
    logic                    w_res;
    logic                    w_fix;
    logic                    w_dbl;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [ADDR_W-1:0]       r_err_addr;
    logic                    r_we;
    logic                    r_valid;
    logic                    r_single;
    logic                    r_double;
    logic                    r_irq;
    logic                    r_pass;
    logic                    r_busy;

    // timer is loaded on entry to WAIT_TMR so that it dwells max(interval,1) cycles
    assign w_load     = (r_state != WAIT_TMR) && (w_next == WAIT_TMR);
    assign w_load_val = (interval == '0) ? '0 : interval - INTERVAL_W'(1);

    scrub_timer #(.W(INTERVAL_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_val   (w_load_val),
        .i_dec   (r_state == WAIT_TMR),
        .o_zero  (w_zero)
    );

    // a decoder result only counts while the read is outstanding
    assign w_res = (r_state == WAIT_DEC) && dec_valid;
    assign w_fix = w_res && dec_single && !dec_double;
    assign w_dbl = w_res && dec_double;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic; enable is only consulted at word boundaries so accesses never abort
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = enable ? WAIT_TMR : IDLE;
            WAIT_TMR: w_next = w_zero ? READ : WAIT_TMR;
            READ:     w_next = (mem_req && mem_gnt) ? WAIT_DEC : READ;
            WAIT_DEC: w_next = !dec_valid ? WAIT_DEC : (w_fix ? WRITE : NEXT);
            WRITE:    w_next = (mem_req && mem_gnt) ? NEXT : WRITE;
            NEXT:     w_next = enable ? WAIT_TMR : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // the request yields to host traffic combinationally
    always_comb begin
        mem_req = ((r_state == READ) || (r_state == WRITE)) && !host_busy;
    end

    // registered datapath: address walk, write-back data, result strobes and error log
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err_addr <= '0;
            r_we       <= 1'b0;
            r_valid    <= 1'b0;
            r_single   <= 1'b0;
            r_double   <= 1'b0;
            r_irq      <= 1'b0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_we     <= (w_next == WRITE);
            r_busy   <= (w_next != IDLE);
            r_pass   <= (w_next == NEXT) && (r_addr == LAST_ADDR);
            r_valid  <= w_res;
            r_single <= w_fix;
            r_double <= w_dbl;
            if (w_fix) begin
                r_wdata <= dec_data;
            end
            if (w_dbl) begin
                r_err_addr <= r_addr;
            end
            if (w_dbl) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
            if (r_state == NEXT) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
            end
        end
    end

    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign scrub_valid  = r_valid;
    assign scrub_single = r_single;
    assign scrub_double = r_double;
    assign err_addr     = r_err_addr;
    assign err_irq      = r_irq;
    assign pass_done    = r_pass;
    assign busy         = r_busy;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: access-level scoreboard bench for the scrub controller
module tb_ecc_scrub_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int IW    = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [IW-1:0] interval;
    logic          host_busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          dec_valid;
    logic [DW-1:0] dec_data;
    logic          dec_single;
    logic          dec_double;
    logic          scrub_valid;
    logic          scrub_single;
    logic          scrub_double;
    logic [AW-1:0] err_addr;
    logic          err_irq;
    logic          irq_clr;
    logic          pass_done;
    logic          busy;

    ecc_scrub_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .INTERVAL_W(IW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .interval     (interval),
        .host_busy    (host_busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_single   (dec_single),
        .dec_double   (dec_double),
        .scrub_valid  (scrub_valid),
        .scrub_single (scrub_single),
        .scrub_double (scrub_double),
        .err_addr     (err_addr),
        .err_irq      (err_irq),
        .irq_clr      (irq_clr),
        .pass_done    (pass_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus knobs
    int k_hb, k_gnt, k_gnt_wr, k_clr, k_stray, k_rand, k_sgl, k_dbl, k_clr_dbl, k_lat_min, k_lat_max;
    int hb_force = 0;
    logic clr_once = 1'b0;

    // reference model: next address to scrub, pending write-back, expected registered outputs
    int            m_addr;
    logic          m_wb;
    logic [DW-1:0] m_wbd;
    logic          pend;
    int            dcnt;
    logic          m_v, m_s, m_d, m_irq, m_pass;
    logic [AW-1:0] m_eaddr;

    // observation counters
    int cyc_n = 0, n_rd = 0, n_wr = 0, n_valid = 0, n_sgl = 0, n_dbl = 0, n_pass = 0, n_fire = 0;
    int last_gap = 0, last_rd_cyc = 0;
    logic [AW-1:0] last_rd_addr, last_wr_addr, last_addr;
    logic [DW-1:0] last_wr_data;
    logic          last_req, last_we;

    task automatic knobs_default();
        k_hb = 0; k_gnt = 100; k_gnt_wr = 100; k_clr = 0; k_stray = 0; k_rand = 0;
        k_sgl = -1; k_dbl = -1; k_clr_dbl = 0; k_lat_min = 1; k_lat_max = 1;
    endtask

    task automatic model_clear();
        m_addr = 0; m_wb = 1'b0; m_wbd = '0; pend = 1'b0; dcnt = 0;
        m_v = 1'b0; m_s = 1'b0; m_d = 1'b0; m_irq = 1'b0; m_pass = 1'b0; m_eaddr = '0;
        hb_force = 0; clr_once = 1'b0;
        dec_valid = 1'b0; dec_single = 1'b0; dec_double = 1'b0; dec_data = '0;
        mem_gnt = 1'b0; irq_clr = 1'b0; host_busy = 1'b0;
    endtask

    // one clock: drive memory/decoder responses, check outputs, advance the model
    task automatic cyc();
        logic       sgl, dbl, fire;
        logic [1:0] r;
        sgl = 1'b0; dbl = 1'b0; fire = 1'b0;
        @(negedge clk);
        host_busy = (hb_force > 0) || (int'($urandom_range(99)) < k_hb);
        if (hb_force > 0) hb_force--;
        irq_clr = clr_once || (int'($urandom_range(99)) < k_clr);
        clr_once = 1'b0;
        dec_valid = 1'b0; dec_single = 1'b0; dec_double = 1'b0;
        dec_data = {$urandom, $urandom};
        if (pend && dcnt == 0) begin
            fire = 1'b1;
            pend = 1'b0;
            if (k_rand != 0) begin
                r = 2'($urandom_range(3));
                sgl = r[0];
                dbl = r[1];
            end else begin
                sgl = (m_addr == k_sgl);
                dbl = (m_addr == k_dbl);
            end
            if (sgl && m_addr == k_sgl) dec_data = 64'hA5A5;
            if (dbl && k_clr_dbl != 0) irq_clr = 1'b1;
            dec_valid = 1'b1; dec_single = sgl; dec_double = dbl;
        end else if (pend) begin
            dcnt--;
        end else if (int'($urandom_range(99)) < k_stray) begin
            dec_valid = 1'b1; dec_single = 1'($urandom); dec_double = 1'($urandom);
        end
        #1;
        n_checks++;
        if ({scrub_valid, scrub_single, scrub_double} !== {m_v, m_s, m_d}) begin
            n_errors++;
            $display("FAIL strobes cyc=%0d got=%b exp=%b", cyc_n, {scrub_valid, scrub_single, scrub_double}, {m_v, m_s, m_d});
        end
        n_checks++;
        if (err_irq !== m_irq) begin
            n_errors++;
            $display("FAIL err_irq cyc=%0d got=%b exp=%b", cyc_n, err_irq, m_irq);
        end
        n_checks++;
        if (err_addr !== m_eaddr) begin
            n_errors++;
            $display("FAIL err_addr cyc=%0d got=%0d exp=%0d", cyc_n, err_addr, m_eaddr);
        end
        n_checks++;
        if (pass_done !== m_pass) begin
            n_errors++;
            $display("FAIL pass_done cyc=%0d got=%b exp=%b", cyc_n, pass_done, m_pass);
        end
        n_checks++;
        if (host_busy && mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL req_while_busy cyc=%0d got=%b exp=0", cyc_n, mem_req);
        end
        n_valid += int'(scrub_valid); n_sgl += int'(scrub_single);
        n_dbl += int'(scrub_double); n_pass += int'(pass_done);
        last_req = mem_req; last_we = mem_we; last_addr = mem_addr;
        mem_gnt = mem_req && (int'($urandom_range(99)) < (mem_we ? k_gnt_wr : k_gnt));
        m_pass = 1'b0;
        if (mem_gnt && mem_we) begin
            n_checks++;
            if (!m_wb || mem_addr !== AW'(m_addr) || mem_wdata !== m_wbd) begin
                n_errors++;
                $display("FAIL write cyc=%0d got addr=%0d data=%h exp pending=%b addr=%0d data=%h", cyc_n, mem_addr, mem_wdata, m_wb, m_addr, m_wbd);
            end
            n_wr++; last_wr_addr = mem_addr; last_wr_data = mem_wdata;
            m_wb = 1'b0;
            m_pass = (m_addr == DEPTH - 1);
            m_addr = (m_addr + 1) % DEPTH;
        end else if (mem_gnt) begin
            n_checks++;
            if (m_wb || pend || mem_addr !== AW'(m_addr)) begin
                n_errors++;
                $display("FAIL read cyc=%0d got addr=%0d exp addr=%0d wb_pending=%b outstanding=%b", cyc_n, mem_addr, m_addr, m_wb, pend);
            end
            pend = 1'b1;
            dcnt = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
            n_rd++; last_gap = cyc_n - last_rd_cyc; last_rd_cyc = cyc_n; last_rd_addr = mem_addr;
        end
        m_v = fire; m_s = fire && sgl && !dbl; m_d = fire && dbl;
        m_irq = (fire && dbl) ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
        if (fire && dbl) m_eaddr = AW'(m_addr);
        if (fire && sgl && !dbl) begin
            m_wb = 1'b1; m_wbd = dec_data;
        end else if (fire) begin
            m_pass = (m_addr == DEPTH - 1);
            m_addr = (m_addr + 1) % DEPTH;
        end
        n_fire += int'(fire);
        cyc_n++;
    endtask

    task automatic drain();
        enable = 1'b0;
        knobs_default();
        for (int i = 0; i < 300 && (busy || pend || m_wb); i++) cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_idle got busy=%b exp=0", busy);
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; interval = '0;
        knobs_default(); model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, scrub_valid, scrub_single, scrub_double, err_addr, err_irq, pass_done, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata, scrub_valid, scrub_single, scrub_double, err_addr, err_irq, pass_done, busy});
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_clean_pass();
        int b_r, b_v, b_p;
        b_r = n_rd; b_v = n_valid; b_p = n_pass;
        knobs_default(); interval = '0; enable = 1'b1;
        for (int i = 0; i < 200 && n_rd - b_r < 5; i++) begin
            cyc();
            if (mem_gnt && !mem_we && n_rd - b_r > 1) begin
                n_checks++;
                if (last_gap != 4) begin
                    n_errors++;
                    $display("FAIL min_latency got=%0d exp=4", last_gap);
                end
            end
        end
        n_checks++;
        if (n_rd - b_r != 5) begin n_errors++; $display("FAIL clean_reads got=%0d exp=5", n_rd - b_r); end
        n_checks++;
        if (n_valid - b_v != 4) begin n_errors++; $display("FAIL clean_valid got=%0d exp=4", n_valid - b_v); end
        n_checks++;
        if (n_pass - b_p != 1) begin n_errors++; $display("FAIL clean_pass_done got=%0d exp=1", n_pass - b_p); end
        n_checks++;
        if (last_rd_addr !== AW'(0)) begin n_errors++; $display("FAIL wrap_addr got=%0d exp=0", last_rd_addr); end
        drain();
    endtask

    task automatic test_single_error();
        int b_w, b_s;
        b_w = n_wr; b_s = n_sgl;
        knobs_default(); k_sgl = 2; enable = 1'b1;
        for (int i = 0; i < 300 && n_wr == b_w; i++) cyc();
        n_checks++;
        if (n_wr - b_w != 1) begin n_errors++; $display("FAIL single_writes got=%0d exp=1", n_wr - b_w); end
        n_checks++;
        if (last_wr_addr !== AW'(2)) begin n_errors++; $display("FAIL single_wr_addr got=%0d exp=2", last_wr_addr); end
        n_checks++;
        if (last_wr_data !== 64'hA5A5) begin n_errors++; $display("FAIL single_wr_data got=%h exp=a5a5", last_wr_data); end
        n_checks++;
        if (n_sgl - b_s != 1) begin n_errors++; $display("FAIL single_strobe got=%0d exp=1", n_sgl - b_s); end
        drain();
    endtask

    task automatic test_double_error();
        int b_w, b_d;
        b_w = n_wr; b_d = n_dbl;
        knobs_default(); k_dbl = 1; enable = 1'b1;
        for (int i = 0; i < 300 && n_dbl == b_d; i++) cyc();
        n_checks++;
        if (err_irq !== 1'b1 || err_addr !== AW'(1)) begin
            n_errors++;
            $display("FAIL double_log got irq=%b addr=%0d exp irq=1 addr=1", err_irq, err_addr);
        end
        n_checks++;
        if (n_wr != b_w) begin n_errors++; $display("FAIL double_no_write got=%0d exp=0", n_wr - b_w); end
        repeat (3) cyc();
        n_checks++;
        if (err_irq !== 1'b1) begin n_errors++; $display("FAIL irq_sticky got=%b exp=1", err_irq); end
        clr_once = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (err_irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear got=%b exp=0", err_irq); end
        k_clr_dbl = 1;
        for (int i = 0; i < 300 && n_dbl - b_d < 2; i++) cyc();
        n_checks++;
        if (n_dbl - b_d != 2 || err_irq !== 1'b1) begin
            n_errors++;
            $display("FAIL set_beats_clear got doubles=%0d irq=%b exp doubles=2 irq=1", n_dbl - b_d, err_irq);
        end
        drain();
    endtask

    task automatic test_host_busy();
        int b_f, b_r;
        b_f = n_fire;
        knobs_default(); interval = '0; enable = 1'b1;
        for (int i = 0; i < 100 && n_fire == b_f; i++) cyc();
        hb_force = 8;
        b_r = n_rd;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++;
            if (mem_req !== 1'b0) begin n_errors++; $display("FAIL hb_req cyc=%0d got=%b exp=0", cyc_n, mem_req); end
        end
        n_checks++;
        if (n_rd != b_r) begin n_errors++; $display("FAIL hb_reads got=%0d exp=0", n_rd - b_r); end
        cyc();
        n_checks++;
        if ({last_req, last_we} !== 2'b10 || n_rd != b_r + 1 || last_rd_addr !== AW'(m_addr)) begin
            n_errors++;
            $display("FAIL hb_release got req=%b we=%b reads=%0d addr=%0d exp req=1 we=0 reads=1 addr=%0d", last_req, last_we, n_rd - b_r, last_addr, m_addr);
        end
        drain();
    endtask

    task automatic test_interval_enable();
        int b_r, b_w, sa;
        b_r = n_rd;
        knobs_default(); interval = IW'(3); enable = 1'b1;
        for (int i = 0; i < 200 && n_rd - b_r < 3; i++) begin
            cyc();
            if (mem_gnt && !mem_we && n_rd - b_r > 1) begin
                n_checks++;
                if (last_gap != 6) begin n_errors++; $display("FAIL interval_gap got=%0d exp=6", last_gap); end
            end
        end
        sa = m_addr;
        k_sgl = sa;
        enable = 1'b0;
        b_w = n_wr;
        for (int i = 0; i < 100 && busy; i++) cyc();
        n_checks++;
        if (n_wr - b_w != 1 || last_wr_addr !== AW'(sa)) begin
            n_errors++;
            $display("FAIL disable_wb got writes=%0d addr=%0d exp writes=1 addr=%0d", n_wr - b_w, last_wr_addr, sa);
        end
        repeat (10) cyc();
        n_checks++;
        if (n_rd - b_r != 3 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL disable_idle got reads=%0d busy=%b exp reads=3 busy=0", n_rd - b_r, busy);
        end
        enable = 1'b1;
        for (int i = 0; i < 100 && n_rd - b_r < 4; i++) cyc();
        n_checks++;
        if (n_rd - b_r != 4 || last_rd_addr !== AW'((sa + 1) % DEPTH)) begin
            n_errors++;
            $display("FAIL resume_addr got=%0d exp=%0d", last_rd_addr, (sa + 1) % DEPTH);
        end
        drain();
        interval = '0;
    endtask

    task automatic test_reset_mid_write();
        int b_r;
        knobs_default(); k_sgl = m_addr; k_gnt_wr = 0; enable = 1'b1;
        for (int i = 0; i < 100 && !(last_req && last_we); i++) cyc();
        n_checks++;
        if ({last_req, last_we} !== 2'b11) begin n_errors++; $display("FAIL reach_write got req=%b we=%b exp=11", last_req, last_we); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, scrub_valid, scrub_single, scrub_double, err_addr, err_irq, pass_done, busy} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata, scrub_valid, scrub_single, scrub_double, err_addr, err_irq, pass_done, busy});
        end
        model_clear();
        knobs_default();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        b_r = n_rd;
        for (int i = 0; i < 100 && n_rd == b_r; i++) cyc();
        n_checks++;
        if (n_rd - b_r != 1 || last_rd_addr !== AW'(0)) begin
            n_errors++;
            $display("FAIL restart_addr got reads=%0d addr=%0d exp reads=1 addr=0", n_rd - b_r, last_rd_addr);
        end
        drain();
    endtask

    task automatic test_random();
        int b_f, b_v;
        b_f = n_fire; b_v = n_valid;
        knobs_default();
        k_lat_min = 1; k_lat_max = 4; k_gnt = 70; k_gnt_wr = 60; k_hb = 30;
        k_clr = 10; k_stray = 10; k_rand = 1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) begin
                interval = IW'($urandom_range(3));
                enable = ($urandom_range(3) != 0);
            end
            cyc();
        end
        drain();
        n_checks++;
        if (n_fire - b_f < 20 || n_valid - b_v != n_fire - b_f) begin
            n_errors++;
            $display("FAIL random_results got valid=%0d exp=%0d", n_valid - b_v, n_fire - b_f);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_single_error();
        test_double_error();
        test_host_busy();
        test_interval_enable();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
